add_sched: RTL and testbench

- Two-requester scheduler that shares one 4-bit nibble adder to perform WIDTH-bit additions.
- Each request is a pair of WIDTH-bit operands. It is accepted via valid/ready, executed one nibble per cycle (LSB nibble first) with a carry register, and returned on a single result channel tagged with the requester ID.
- Sits between multiple arithmetic clients and the shared 4-bit adder datapath.

---
 rtl/add_sched.sv | 159 +++++++++++++++
 tb/tb_add_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/add_sched.sv
// ---------------------------------------------------------------------------
// add_sched -- two-requester scheduler sharing one 4-bit nibble adder
//
// Purpose:
//   Accepts WIDTH-bit operand pairs from two requesters (round-robin on
//   ties), adds them one nibble per cycle (LSB nibble first) through a single
//   4-bit adder with a carry register, and returns the sum on one result
//   channel tagged with the requester ID.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/ready/a/b      requester 0 operand channel
//   req1_valid/ready/a/b      requester 1 operand channel
//   res_valid/ready           result handshake
//   res_sum, res_cout, res_id result sum, carry out of MSB nibble, requester ID
//
// Build option:
//   ADD_SCHED_SAT_EN  when defined, a result with final carry=1 presents
//                     res_sum as all ones (saturating add); res_cout still 1.
// ---------------------------------------------------------------------------
module add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               gnt_any;
    logic               gnt_id;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [4:0]         nib_res;
    logic               add_step;

    // Round-robin grant: on a tie the requester that was not served last wins.
    assign gnt_any = req0_valid | req1_valid;
    assign gnt_id  = req0_valid ? (req1_valid ? ~last_q : 1'b0) : 1'b1;

    // The single shared nibble adder.
    assign nib_a    = a_q[idx_q*4 +: 4];
    assign nib_b    = b_q[idx_q*4 +: 4];
    assign nib_res  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    assign add_step = (state_q == S_ADD);

    // Each sum nibble is written exactly once per operation, in its own step.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_sum_nib
            assign sum_d[gi*4 +: 4] =
                (add_step && (idx_q == IDX_W'(gi))) ? nib_res[3:0]
                                                    : sum_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    a_d        = gnt_id ? req1_a : req0_a;
                    b_d        = gnt_id ? req1_b : req0_b;
                    id_d       = gnt_id;
                    last_d     = gnt_id;
                    carry_d    = 1'b0;
                    idx_d      = '0;
                    state_d    = S_ADD;
                end
            end
            S_ADD: begin
                carry_d = nib_res[4];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIB - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // After the last ADD step the carry register holds the MSB-nibble carry.
    assign res_valid = (state_q == S_DONE);
    assign res_cout  = carry_q;
    assign res_id    = id_q;

`ifdef ADD_SCHED_SAT_EN
    assign res_sum = ((state_q == S_DONE) && carry_q) ? {WIDTH{1'b1}} : sum_q;
`else
    assign res_sum = sum_q;
`endif

endmodule

// File: tb/tb_add_sched.sv
// ---------------------------------------------------------------------------
// tb_add_sched -- self-checking bench for add_sched (WIDTH=16)
//
// A transaction-level model predicts the grant (round-robin rule), the sum
// (plain integer addition, optional saturation) and the cycle-exact timing
// of res_valid. Inputs are driven 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_add_sched;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
`ifdef ADD_SCHED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout, res_id;

    int n_checks = 0;
    int n_errors = 0;
    bit last_m;     // model's round-robin memory: requester served last

    always #5 clk = ~clk;

    add_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic noise_inputs();
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_a     = WIDTH'($urandom);
        req0_b     = WIDTH'($urandom);
        req1_a     = WIDTH'($urandom);
        req1_b     = WIDTH'($urandom);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                          input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                          input int stall);
        bit               g;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] esum;
        bit               ecout;

        g     = (v0 && v1) ? ~last_m : (v0 ? 1'b0 : 1'b1);
        full  = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        ecout = full[WIDTH];
        esum  = (SAT && ecout) ? {WIDTH{1'b1}} : full[WIDTH-1:0];

        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;

        @(negedge clk);
        check("grant_rdy0", req0_ready, (g == 1'b0));
        check("grant_rdy1", req1_ready, (g == 1'b1));
        check("idle_valid", res_valid, 0);

        @(posedge clk); #1;
        last_m = g;
        noise_inputs();                 // must be ignored while busy
        res_ready = 1'($urandom);       // no effect outside DONE

        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            check("add_valid", res_valid, 0);
            check("add_rdy0", req0_ready, 0);
            check("add_rdy1", req1_ready, 0);
            noise_inputs();
            res_ready = 1'($urandom);
        end

        @(negedge clk);
        check("done_valid", res_valid, 1);
        check("done_sum", res_sum, esum);
        check("done_cout", res_cout, ecout);
        check("done_id", res_id, g);
        check("done_rdy0", req0_ready, 0);
        check("done_rdy1", req1_ready, 0);
        res_ready = (stall == 0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_sum", res_sum, esum);
            check("hold_cout", res_cout, ecout);
            check("hold_id", res_id, g);
            check("hold_rdy0", req0_ready, 0);
            check("hold_rdy1", req1_ready, 0);
            noise_inputs();
            if (s == stall - 1) res_ready = 1'b1;
        end

        @(posedge clk); #1;
        res_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("post_valid", res_valid, 0);
        check("post_rdy0", req0_ready, 0);
        check("post_rdy1", req1_ready, 0);
        $display("txn id=%0d a=0x%04h b=0x%04h -> sum=0x%04h cout=%0d stall=%0d",
                 g, g ? a1 : a0, g ? b1 : b0, esum, ecout, stall);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        last_m = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", res_valid, 0);
        check("rst_sum", res_sum, 0);
        check("rst_cout", res_cout, 0);
        check("rst_id", res_id, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Arbitration: tie after reset goes to req0, then alternates.
        do_txn(1, 1, 16'h0007, 16'h0009, 16'h00F0, 16'h0010, 0);
        do_txn(1, 1, 16'h0007, 16'h0009, 16'h00F0, 16'h0010, 0);
        do_txn(1, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0);
        do_txn(0, 1, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 0);
        do_txn(0, 1, 16'h0000, 16'h0000, 16'h0F0F, 16'h00F1, 0);

        // Basic add and carry ripple with backpressure.
        do_txn(1, 0, 16'h1234, 16'h0FFF, 16'h0000, 16'h0000, 0);
        do_txn(0, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 3);

        // Reset during the second ADD cycle discards the operation.
        req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111;
        @(negedge clk);
        check("rstop_rdy0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_m = 1'b1;
        @(negedge clk);
        check("rstop_valid", res_valid, 0);
        check("rstop_sum", res_sum, 0);
        check("rstop_id", res_id, 0);
        for (int i = 0; i < NIB + 3; i++) begin
            @(negedge clk);
            check("rstop_nores", res_valid, 0);
        end
        res_ready = 1'b0;
        @(posedge clk); #1;
        do_txn(1, 0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            int r;
            r = $urandom_range(1, 3);
            do_txn(r[0], r[1], WIDTH'($urandom), WIDTH'($urandom),
                   WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge clk);
                check("gap_rdy0", req0_ready, 0);
                check("gap_rdy1", req1_ready, 0);
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
